// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 memory path.
//  - mem_state_e : bus-initiator FSM states (idle / request / recover)
//  - MMIO address constants shared by the controller, RAM and bench
package lc3_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StRecover = 2'd2
    } mem_state_e;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;
    localparam logic [15:0] MCR  = 16'hFFFE;

endpackage

// File: rtl/lc3_mem_timeout.sv
// lc3_mem_timeout: wait counter for an outstanding RAM request.
// Only compiled when LC3_MEM_TIMEOUT_EN is defined.
// Ports:
//  clk, rst_n  : clock, asynchronous active-low reset
//  i_clr       : clear the count (request accepted)
//  i_inc       : count one request cycle without ready
//  o_expired   : the current non-ready cycle is the TIMEOUT-th one
`ifdef LC3_MEM_TIMEOUT_EN
module lc3_mem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Not gated by i_inc to keep the controller's next-state logic loop-free;
    // the controller only acts on it in a non-ready request cycle.
    assign o_expired = (r_cnt == LAST);

endmodule
`endif

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: CPU-side bus initiator for the LC-3 synchronous RAM.
// Holds MAR/MDR, drives one RAM request at a time and reports a one-cycle done.
// Optional feature macro: LC3_MEM_TIMEOUT_EN (abort a request after TIMEOUT cycles).
// Ports:
//  clk, rst_n              : clock, asynchronous active-low reset
//  i_cpu_req/we/addr/wdata : access request, sampled only in idle
//  o_cpu_busy              : access in progress
//  o_cpu_done / o_cpu_err  : completion pulse / completion was a timeout abort
//  o_cpu_rdata             : last completed read data
//  o_mem_cs/r_w/addr/wdata : RAM request (registered)
//  i_mem_ready/rdata       : RAM registered ready and read data
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_busy,
    output logic                  o_cpu_done,
    output logic                  o_cpu_err,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_mem_cs,
    output logic                  o_mem_r_w,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    mem_state_e            r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_mar, w_mar_d;
    logic [DATA_WIDTH-1:0] r_mdr, w_mdr_d;
    // Separate from MDR so CPU writes never disturb the read result.
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
    logic                  r_cs, w_cs_d;
    logic                  r_rw, w_rw_d;
    logic                  r_done, w_done_d;

`ifdef LC3_MEM_TIMEOUT_EN
    logic r_err, w_err_d;
    logic w_tmo_clr, w_tmo_inc, w_tmo_expired;

    lc3_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_tmo_clr),
        .i_inc     (w_tmo_inc),
        .o_expired (w_tmo_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_rdata <= '0;
            r_cs    <= 1'b0;
            r_rw    <= 1'b0;
            r_done  <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_mar   <= w_mar_d;
            r_mdr   <= w_mdr_d;
            r_rdata <= w_rdata_d;
            r_cs    <= w_cs_d;
            r_rw    <= w_rw_d;
            r_done  <= w_done_d;
`ifdef LC3_MEM_TIMEOUT_EN
            r_err   <= w_err_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_mar_d   = r_mar;
        w_mdr_d   = r_mdr;
        w_rdata_d = r_rdata;
        w_cs_d    = r_cs;
        w_rw_d    = r_rw;
        w_done_d  = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
        w_err_d   = 1'b0;
        w_tmo_clr = 1'b0;
        w_tmo_inc = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (i_cpu_req) begin
                    w_mar_d   = i_cpu_addr;
                    if (i_cpu_we) begin
                        w_mdr_d = i_cpu_wdata;
                    end
                    w_rw_d    = i_cpu_we;
                    w_cs_d    = 1'b1;
                    w_state_d = StReq;
`ifdef LC3_MEM_TIMEOUT_EN
                    w_tmo_clr = 1'b1;
`endif
                end
            end
            StReq: begin
                // Ready has priority over a simultaneous timeout.
                if (i_mem_ready) begin
                    if (!r_rw) begin
                        w_mdr_d   = i_mem_rdata;
                        w_rdata_d = i_mem_rdata;
                    end
                    w_cs_d    = 1'b0;
                    w_rw_d    = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = StRecover;
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else begin
                    w_tmo_inc = 1'b1;
                    if (w_tmo_expired) begin
                        w_cs_d    = 1'b0;
                        w_rw_d    = 1'b0;
                        w_done_d  = 1'b1;
                        w_err_d   = 1'b1;
                        w_state_d = StRecover;
                    end
                end
`endif
            end
            StRecover: begin
                // RAM ready lags cs by an edge; wait for it to fall before reuse.
                if (!i_mem_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_cpu_busy  = (r_state != StIdle);
    assign o_cpu_done  = r_done;
    assign o_cpu_rdata = r_rdata;
    assign o_mem_cs    = r_cs;
    assign o_mem_r_w   = r_rw;
    assign o_mem_addr  = r_mar;
    assign o_mem_wdata = r_mdr;
`ifdef LC3_MEM_TIMEOUT_EN
    assign o_cpu_err   = r_err;
`else
    assign o_cpu_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: self-checking bench for lc3_mem_ctrl with a single-cycle RAM stub.
// A transaction-level model (cycles since accept, expected memory image) is compared
// against the DUT outputs on every falling edge; directed cases pin literal values.
module tb_lc3_mem_ctrl;
    import lc3_pkg::*;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [15:0] cpu_rdata;
    logic        mem_cs, mem_r_w;
    logic [15:0] mem_addr, mem_wdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // RAM stub: registered ready that pulses once per request.
    logic [15:0] ram [0:65535];
    logic        ram_ready = 1'b0;
    logic [15:0] ram_rdata = '0;
    bit          ram_stall = 1'b0;

    always @(posedge clk) begin
        if (mem_cs && !ram_ready && !ram_stall) begin
            ram_ready <= 1'b1;
            ram_rdata <= ram[mem_addr];
            if (mem_r_w) ram[mem_addr] <= mem_wdata;
        end else begin
            ram_ready <= 1'b0;
        end
    end

    lc3_mem_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_busy  (cpu_busy),
        .o_cpu_done  (cpu_done),
        .o_cpu_err   (cpu_err),
        .o_cpu_rdata (cpu_rdata),
        .o_mem_cs    (mem_cs),
        .o_mem_r_w   (mem_r_w),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ready (ram_ready),
        .i_mem_rdata (ram_rdata)
    );

    // Reference model: m_k = edges since the last accepted request, m_d = edge of completion.
    logic [15:0] m_mem [0:65535];
    int          m_k = 1000;
    int          m_d = 2;
    bit          m_we = 1'b0;
    bit          m_stall = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_mdr = '0;
    logic [15:0] m_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 1000; m_d = 2; m_we = 1'b0; m_stall = 1'b0;
            m_addr = '0; m_mdr = '0; m_rdata = '0;
        end else begin
            if (m_k < 1000) m_k++;
            if (m_k >= m_d + 2 && cpu_req) begin
                m_k = 0;
                m_addr = cpu_addr;
                m_we = cpu_we;
                m_stall = ram_stall;
                m_d = ram_stall ? int'(TMO) : 2;
                if (cpu_we) begin
                    m_mdr = cpu_wdata;
                    if (!ram_stall) m_mem[cpu_addr] = cpu_wdata;
                end
            end else if (m_k == m_d && !m_we && !m_stall) begin
                m_mdr = m_mem[m_addr];
                m_rdata = m_mdr;
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk1("m_busy", cpu_busy, m_k <= m_d);
        chk1("m_done", cpu_done, m_k == m_d);
        chk1("m_err", cpu_err, (m_k == m_d) && m_stall);
        chk1("m_cs", mem_cs, m_k < m_d);
        chk1("m_rw", mem_r_w, (m_k < m_d) && m_we);
        chk16("m_addr", mem_addr, m_addr);
        chk16("m_wdata", mem_wdata, m_mdr);
        chk16("m_rdata", cpu_rdata, m_rdata);
    end

    task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d,
                          output int cyc, output bit cs1);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        cyc = 0;
        cs1 = 1'b0;
        do begin
            @(negedge clk);
            cpu_req = 1'b0;
            cyc++;
            if (cyc == 1) cs1 = mem_cs;
        end while (!cpu_done && cyc < 40);
        if (!cpu_done) begin
            total++;
            bad++;
            $display("FAIL access_wait: no done after %0d cycles addr %h", cyc, a);
        end
    endtask

    initial begin
        int cyc;
        bit cs1;
        int ndone;

        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i * 7 + 3);
            m_mem[i] = 16'(i * 7 + 3);
        end
        ram[16'h3000] = 16'h1234;
        m_mem[16'h3000] = 16'h1234;

        // Reset held with a pending request.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1111; cpu_wdata = 16'h2222;
        repeat (3) @(negedge clk);
        chk1("rst_cs", mem_cs, 1'b0);
        chk1("rst_busy", cpu_busy, 1'b0);
        chk16("rst_addr", mem_addr, 16'h0000);
        cpu_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("idle_busy", cpu_busy, 1'b0);

        // Read with literal timing.
        access(1'b0, 16'h3000, 16'h0000, cyc, cs1);
        chk1("rd_cs_next", cs1, 1'b1);
        chk16("rd_latency", 16'(cyc), 16'd3);
        chk16("rd_data", cpu_rdata, 16'h1234);
        chk1("rd_err", cpu_err, 1'b0);

        // Write then read back.
        access(1'b1, 16'h4000, 16'hBEEF, cyc, cs1);
        chk16("wr_rdata_kept", cpu_rdata, 16'h1234);
        @(negedge clk);
        chk16("wr_ram", ram[16'h4000], 16'hBEEF);
        access(1'b0, 16'h4000, 16'h0000, cyc, cs1);
        chk16("wr_rd_data", cpu_rdata, 16'hBEEF);

        // Request while busy is dropped.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        @(negedge clk);
        cpu_addr = 16'h3001;
        @(negedge clk);
        cpu_req = 1'b0;
        chk16("drop_addr", mem_addr, 16'h3000);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_done) ndone++;
        end
        chk16("drop_ndone", 16'(ndone), 16'd1);
        access(1'b0, 16'h3001, 16'h0000, cyc, cs1);
        chk16("drop_next", cpu_rdata, 16'h500A);

        // Asynchronous reset mid-request.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        @(negedge clk);
        cpu_req = 1'b0;
        chk1("arst_pre_cs", mem_cs, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("arst_cs", mem_cs, 1'b0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_done) ndone++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_done) ndone++;
        end
        chk16("arst_ndone", 16'(ndone), 16'd0);
        chk16("arst_rdata", cpu_rdata, 16'h0000);
        access(1'b0, 16'h4000, 16'h0000, cyc, cs1);
        chk16("arst_restart", cpu_rdata, 16'hBEEF);

        // All-ones address and data pass through.
        access(1'b1, 16'hFFFF, 16'hFFFF, cyc, cs1);
        chk16("ff_addr", mem_addr, 16'hFFFF);
        chk16("ff_wdata", mem_wdata, 16'hFFFF);
        access(1'b0, 16'hFFFF, 16'h0000, cyc, cs1);
        chk16("ff_rdata", cpu_rdata, 16'hFFFF);

`ifdef LC3_MEM_TIMEOUT_EN
        // RAM never answers: abort after TMO request cycles.
        @(negedge clk);
        ram_stall = 1'b1;
        access(1'b0, 16'h3000, 16'h0000, cyc, cs1);
        chk16("tmo_latency", 16'(cyc), 16'(TMO + 1));
        chk1("tmo_err", cpu_err, 1'b1);
        chk16("tmo_rdata", cpu_rdata, 16'hFFFF);
        @(negedge clk);
        chk1("tmo_busy_clear", cpu_busy, 1'b0);
        ram_stall = 1'b0;
`endif

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: cpu_addr = KBSR;
                1: cpu_addr = KBDR;
                2: cpu_addr = DSR;
                3: cpu_addr = DDR;
                4: cpu_addr = MCR;
                5: cpu_addr = 16'hFFFF;
                default: cpu_addr = 16'h3000 + 16'($urandom_range(0, 15));
            endcase
            cpu_wdata = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        end
        cpu_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
